// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: bubble encoding, entry layout and occupancy states
// for the fetch/decode handoff stage.
package pipe_stage_skid_pkg;

   localparam int          PC_W_DEF     = 32;
   localparam int          INST_W_DEF   = 32;
   localparam logic [31:0] NOP_INST_DEF = 32'h0400_0000;

   typedef struct packed {
      logic                  valid;
      logic [PC_W_DEF-1:0]   pc;
      logic [INST_W_DEF-1:0] inst;
   } entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } occ_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One {valid, pc, inst} holding register; only the valid bit is reset, the
// payload is don't-care while invalid.
module pipe_entry_reg #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [PC_W-1:0]   d_pc,
   input  logic [INST_W-1:0] d_inst,
   output logic              q_valid,
   output logic [PC_W-1:0]   q_pc,
   output logic [INST_W-1:0] q_inst
);

   // clear dominates load so a flush always wins over a same-cycle fill
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_valid <= 1'b0;
      end else if (clear) begin
         q_valid <= 1'b0;
      end else if (load) begin
         q_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         q_pc   <= d_pc;
         q_inst <= d_inst;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage between fetch and decode: two-entry skid buffer with
// a registered in_ready (SKID=1) or a single pass-through-ready register (SKID=0).
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int                PC_W     = 32,
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF),
   parameter int                SKID     = 1,
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [INST_W-1:0] in_inst,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic [CNT_W-1:0]  stall_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic              head_v;
   logic [PC_W-1:0]   head_pc;
   logic [INST_W-1:0] head_inst;
   logic              head_load;
   logic              head_clear;
   logic [PC_W-1:0]   head_d_pc;
   logic [INST_W-1:0] head_d_inst;
   logic              accept;
   logic              rel;

   assign accept = in_valid & in_ready;
   assign rel    = head_v & out_ready;

   pipe_entry_reg #(.PC_W(PC_W), .INST_W(INST_W)) u_head (
      .clk     (clk),
      .rst     (rst),
      .load    (head_load),
      .clear   (head_clear),
      .d_pc    (head_d_pc),
      .d_inst  (head_d_inst),
      .q_valid (head_v),
      .q_pc    (head_pc),
      .q_inst  (head_inst)
   );

   if (SKID != 0) begin : g_skid
      logic              skid_v;
      logic [PC_W-1:0]   skid_pc;
      logic [INST_W-1:0] skid_inst;
      logic              skid_load;
      logic              skid_clear;
      logic              head_from_skid;
      occ_e              occ;

      // in_ready comes straight off the skid valid flop; no path from out_ready
      assign in_ready = ~skid_v;

      pipe_entry_reg #(.PC_W(PC_W), .INST_W(INST_W)) u_skid (
         .clk     (clk),
         .rst     (rst),
         .load    (skid_load),
         .clear   (skid_clear),
         .d_pc    (in_pc),
         .d_inst  (in_inst),
         .q_valid (skid_v),
         .q_pc    (skid_pc),
         .q_inst  (skid_inst)
      );

      always_comb begin
         head_load      = 1'b0;
         head_clear     = flush;
         skid_load      = 1'b0;
         skid_clear     = flush;
         head_from_skid = 1'b0;
         occ            = skid_v ? ST_FULL : (head_v ? ST_ONE : ST_EMPTY);
         unique case (occ)
            ST_EMPTY: head_load = accept;
            ST_ONE: begin
               if (accept && rel) begin
                  head_load = 1'b1;
               end else if (accept) begin
                  skid_load = 1'b1;
               end else if (rel) begin
                  head_clear = 1'b1;
               end
            end
            ST_FULL: begin
               if (rel) begin
                  head_load      = 1'b1;
                  head_from_skid = 1'b1;
                  skid_clear     = 1'b1;
               end
            end
            default: head_clear = 1'b1;
         endcase
         head_d_pc   = head_from_skid ? skid_pc   : in_pc;
         head_d_inst = head_from_skid ? skid_inst : in_inst;
      end
   end else begin : g_pass
      assign in_ready = ~head_v | out_ready;

      always_comb begin
         head_load   = accept;
         head_clear  = flush | (rel & ~accept);
         head_d_pc   = in_pc;
         head_d_inst = in_inst;
      end
   end

   always_comb begin
      out_valid = head_v;
      out_pc    = head_v ? head_pc   : '0;
      out_inst  = head_v ? head_inst : NOP_INST;
   end

   // stall accounting ignores flush; only reset clears it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (head_v && !out_ready) begin
         stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter PC_W, default 32, program-counter field width.
REQ-002 Parameter INST_W, default 32, instruction field width.
REQ-003 Parameter NOP_INST, default 32'h0400_0000, bubble encoding driven whenever no valid entry is presented.
REQ-004 Parameter SKID, default 1; 1 selects the two-entry skid mode, 0 selects the single-entry pass-through-ready mode.
REQ-005 Parameter CNT_W, default 16, stall-counter width.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 in_valid  in  1  upstream entry present.
REQ-009 in_ready  out  1  stage accepts the upstream entry this cycle.
REQ-010 in_pc  in  PC_W  upstream PC.
REQ-011 in_inst  in  INST_W  upstream instruction.
REQ-012 flush  in  1  synchronous kill of all held entries.
REQ-013 out_valid  out  1  downstream entry present.
REQ-014 out_ready  in  1  downstream accepts the entry.
REQ-015 out_pc  out  PC_W  head PC, or 0 when out_valid=0.
REQ-016 out_inst  out  INST_W  head instruction, or NOP_INST when out_valid=0.
REQ-017 stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-018 An accept occurs when in_valid and in_ready are both 1; a release occurs when out_valid and out_ready are both 1.
REQ-019 Entries leave in acceptance order; none is duplicated or dropped, except by flush.
REQ-020 SKID=1 storage: a head register and a skid register, each holding {valid, pc, inst}.
REQ-021 SKID=1 in_ready: driven directly from a flop as NOT skid.valid, with no combinational path from out_ready.
REQ-022 SKID=1 states: EMPTY (head invalid), ONE (head valid, skid invalid), FULL (both valid).
REQ-023 EMPTY: accept -> ONE, and the entry appears on out_* the next cycle (1-cycle latency).
REQ-024 ONE, accept and release in the same cycle -> stay ONE, with the new entry in head.
REQ-025 ONE, accept without release -> FULL, with the new entry in skid.
REQ-026 ONE, release only -> EMPTY.
REQ-027 FULL: in_ready=0; release -> ONE, with skid moved to head.
REQ-028 SKID=0 storage: head register only.
REQ-029 SKID=0 in_ready: NOT out_valid OR out_ready (combinational); accept loads head, otherwise a release clears head.valid.
REQ-030 flush=1: both valid bits clear at the edge, and any accept in the same cycle is discarded.
REQ-031 flush=1: out_* show PC 0 / NOP_INST from the next cycle, and in_ready=1 in the cycle after the flush.
REQ-032 flush has priority over accept, release, and skid transfer.
REQ-033 stall_cnt: +1 per stall cycle, holds at all-ones, is unaffected by flush, and clears only on reset.
REQ-034 Data fields of invalid entries are don't-care internally, but out_pc and out_inst are masked as in REQ-015 and REQ-016.

Reset
REQ-035 While rst=1, asynchronously: out_valid=0, skid invalid, out_pc=0, out_inst=NOP_INST, stall_cnt=0, in_ready=1.
REQ-036 A reset mid-FULL discards both entries; the first accept after reset deassertion behaves as from EMPTY.

Structure
REQ-037 A shared pipeline package holds the NOP_INST default constant and the {valid, pc, inst} entry typedef.
REQ-038 One sub-module, pipe_entry_reg, implements a single async-reset entry register with load/clear, instantiated as head and skid.

Verification
REQ-039 Scenario 1: SKID=1, out_ready=1, accept PCs 0x0,0x4,0x8 back-to-back -> out_pc 0x0,0x4,0x8 on consecutive cycles, each 1 cycle after accept, and in_ready constant 1.
REQ-040 Scenario 2: SKID=1, out_ready=0, offer 0x10,0x14,0x18 -> first two accepted, in_ready=0 afterwards, stall_cnt increments per cycle; raise out_ready -> 0x10,0x14,0x18 in order, no loss.
REQ-041 Scenario 3: FULL state, assert flush together with in_valid=1 for 0x20 -> next cycle out_valid=0, out_inst=0x0400_0000, out_pc=0, in_ready=1, and 0x20 never appears.
REQ-042 Scenario 4: CNT_W=4, hold a stall for 20 cycles -> stall_cnt saturates at 15; flush leaves it at 15; rst clears it to 0.
REQ-043 Scenario 5: SKID=0, out_ready toggling 1,0,1 with in_valid held 1 -> in_ready follows NOT out_valid OR out_ready combinationally, and order is preserved.
REQ-044 Scenario 6: assert rst asynchronously mid-cycle while FULL -> outputs reach reset values before the next clk edge.
